serial_subtractor: RTL and testbench

//   Bit-serial subtractor: computes d = a - b - bin, one bit per clock, LSB first.
//   It is the inverse-operation counterpart of the 4-bit parallel adder and

---
 rtl/serial_subtractor.sv | 98 +++++++++
 tb/tb_serial_subtractor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first.
// Start/done handshake; result and borrow-out are held until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    if (WIDTH < 2 || (2 ** CNT_W) <= WIDTH) begin : g_bad_params
        $error("serial_subtractor: WIDTH/CNT_W out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             x;
    logic             br_nx;
    logic             last;
    logic [WIDTH-1:0] res_nx;

    // one full-subtractor cell, reused every cycle
    assign x      = sa[0] ^ sb[0] ^ br;
    assign br_nx  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign res_nx = {x, res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_nx;
                    res <= res_nx;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        d     <= res_nx;
                        bout  <= br_nx;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model
// compared every cycle, plus directed literal vectors and a full sweep.
module tb_serial_subtractor;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    serial_subtractor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    // reference model: result from plain arithmetic, done after WIDTH cycles
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_d = '0;
    logic             m_bout = 1'b0;
    int               m_rem = 0;
    logic [WIDTH-1:0] p_d = '0;
    logic             p_bout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_d    = '0;
            m_bout = 1'b0;
            m_rem  = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_d    = p_d;
                    m_bout = p_bout;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (start) begin
                p_d    = WIDTH'(int'(a) - int'(b) - int'(bin));
                p_bout = (int'(a) < int'(b) + int'(bin));
                m_rem  = WIDTH;
                m_busy = 1'b1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // one cycle: compare DUT to model mid-cycle, then advance past the next edge
    task automatic step();
        @(negedge clk);
        check("busy", int'(busy), int'(m_busy));
        check("done", int'(done), int'(m_done));
        check("d", int'(d), int'(m_d));
        check("bout", int'(bout), int'(m_bout));
        if (done === 1'b1) n_done++;
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input int ia, input int ib, input int ibin,
                          input int ed, input int eb);
        int lat;
        a     = WIDTH'(ia);
        b     = WIDTH'(ib);
        bin   = ibin[0];
        start = 1'b1;
        step();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 12) begin
            step();
            lat++;
        end
        check("latency", lat, WIDTH + 1);
        check("lit_d", int'(d), ed);
        check("lit_bout", int'(bout), eb);
        step();
    endtask

    initial begin
        int base;
        int guard;

        step();
        step();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_d", int'(d), 0);
        rst_n = 1'b1;
        step();
        step();

        run_op(5, 3, 0, 2, 0);
        run_op(3, 5, 0, 14, 1);
        run_op(15, 15, 0, 0, 0);
        run_op(0, 0, 1, 15, 1);

        // start while busy is ignored; d holds the prior result meanwhile
        base  = n_done;
        a     = 4'd9;
        b     = 4'd1;
        bin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        a     = 4'd0;
        b     = 4'd1;
        start = 1'b1;
        check("hold_busy", int'(busy), 1);
        check("hold_d", int'(d), 15);
        step();
        start = 1'b0;
        check("hold_d2", int'(d), 15);
        guard = 0;
        while (done !== 1'b1 && guard < 12) begin
            step();
            guard++;
        end
        check("ign_d", int'(d), 8);
        check("ign_bout", int'(bout), 0);
        for (int i = 0; i < 8; i++) step();
        check("ign_ndone", n_done - base, 1);

        // reset mid-operation abandons it
        a     = 4'd7;
        b     = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_d", int'(d), 0);
        check("arst_bout", int'(bout), 0);
        base = n_done;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("arst_nodone", n_done - base, 0);
        run_op(7, 2, 0, 5, 0);

        // exhaustive back-to-back sweep
        base = n_done;
        for (int k = 0; k < 512; k++) begin
            a     = WIDTH'(k);
            b     = WIDTH'(k >> 4);
            bin   = k[8];
            start = 1'b1;
            guard = 0;
            while (busy === 1'b1 && guard < 12) begin
                step();
                guard++;
            end
            guard = 0;
            while (busy !== 1'b1 && guard < 12) begin
                step();
                guard++;
            end
            if (guard >= 12) check("sweep_accept", k, -1);
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("sweep_ndone", n_done - base, 512);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
